// File: rtl/reg_bank_param_pkg.sv
// Shared types and helpers for the Redux-V parametrised register bank.
package reg_bank_param_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 2;

  // Dump engine state encoding
  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_LOAD = 2'd1,
    DUMP_SEND = 2'd2,
    DUMP_DONE = 2'd3
  } dump_state_e;

  // Where a read port takes its value from
  typedef enum logic [1:0] {
    SRC_REG   = 2'd0,
    SRC_ZERO  = 2'd1,
    SRC_WDATA = 2'd2
  } rd_src_e;

  // Read-port source select shared by the normal read ports and the dump engine.
  // wr_hit must already exclude discarded writes; the zero register wins over bypass.
  function automatic rd_src_e rd_src(input logic zero_en, input logic byp_en,
                                     input logic addr_is_zero, input logic wr_hit);
    rd_src_e src;
    src = SRC_REG;
    if (zero_en && addr_is_zero) begin
      src = SRC_ZERO;
    end else if (byp_en && wr_hit) begin
      src = SRC_WDATA;
    end
    return src;
  endfunction

endpackage

// File: rtl/reg_bank_dump_fsm.sv
// Debug dump engine: walks every register and streams (index, contents) over valid/ready.
module reg_bank_dump_fsm
  import reg_bank_param_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   dump_start,
  input  logic                                   dump_ready,
  input  logic                                   write_commit,
  input  logic [ADDR_W-1:0]                      write_addr,
  input  logic [DATA_W-1:0]                      write_data,
  input  logic [(1 << ADDR_W)-1:0][DATA_W-1:0]   regs,
  output logic                                   dump_busy,
  output logic                                   dump_valid,
  output logic [ADDR_W-1:0]                      dump_addr,
  output logic [DATA_W-1:0]                      dump_data,
  output logic                                   dump_done
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  rd_src_e           load_src_c;
  logic [DATA_W-1:0] load_val_c;

  // The dump sees a same-cycle write to the index it is loading, whatever BYPASS is
  assign load_src_c = rd_src(ZERO_REG, 1'b1, idx_q == '0,
                             write_commit && (write_addr == idx_q));

  // Value captured for the current beat
  always_comb begin
    load_val_c = regs[idx_q];
    case (load_src_c)
      SRC_ZERO:  load_val_c = '0;
      SRC_WDATA: load_val_c = write_data;
      default:   load_val_c = regs[idx_q];
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      DUMP_IDLE: begin
        if (dump_start) begin
          state_d = DUMP_LOAD;
          idx_d   = '0;
        end
      end
      DUMP_LOAD: begin
        addr_d  = idx_q;
        data_d  = load_val_c;
        state_d = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (dump_ready) begin
          if (&idx_q) begin
            state_d = DUMP_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = DUMP_LOAD;
          end
        end
      end
      DUMP_DONE: state_d = DUMP_IDLE;
      default:   state_d = DUMP_IDLE;
    endcase
    valid_d = (state_d == DUMP_SEND);
    busy_d  = (state_d != DUMP_IDLE);
    done_d  = (state_d == DUMP_DONE);
  end

  // State and output registers; reset aborts any dump in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dump_busy  = busy_q;
  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign dump_done  = done_q;

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register file: one write port, NUM_RD combinational read ports, debug dump.
module reg_bank_param
  import reg_bank_param_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [ADDR_W-1:0]        write_addr,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic [NUM_RD*DATA_W-1:0] r_data,
  input  logic                     dump_start,
  output logic                     dump_busy,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs_c;
  logic                         wr_commit_c;

  // Writes to the hard-wired zero register are dropped
  assign wr_commit_c = write_enable && !(ZERO_REG && (write_addr == '0));

  // Storage: one register per entry
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    logic [DATA_W-1:0] entry_q, entry_d;

    // Load write data when this entry is addressed
    always_comb begin
      entry_d = entry_q;
      if (wr_commit_c && (write_addr == ADDR_W'(i))) begin
        entry_d = write_data;
      end
    end

    // Entry register
    always_ff @(posedge clk) begin
      if (reset) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign regs_c[i] = entry_q;
  end

  // Combinational read ports
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_c;
    rd_src_e           src_c;
    logic [DATA_W-1:0] val_c;

    assign ra_c  = r_addr[k*ADDR_W +: ADDR_W];
    assign src_c = rd_src(ZERO_REG, BYPASS, ra_c == '0,
                          wr_commit_c && (write_addr == ra_c));

    // Port data mux
    always_comb begin
      val_c = regs_c[ra_c];
      case (src_c)
        SRC_ZERO:  val_c = '0;
        SRC_WDATA: val_c = write_data;
        default:   val_c = regs_c[ra_c];
      endcase
    end

    assign r_data[k*DATA_W +: DATA_W] = val_c;
  end

  reg_bank_dump_fsm #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_dump (
    .clk          (clk),
    .reset        (reset),
    .dump_start   (dump_start),
    .dump_ready   (dump_ready),
    .write_commit (wr_commit_c),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .regs         (regs_c),
    .dump_busy    (dump_busy),
    .dump_valid   (dump_valid),
    .dump_addr    (dump_addr),
    .dump_data    (dump_data),
    .dump_done    (dump_done)
  );

endmodule
